// File: rtl/booth_mul_arbiter_if.sv
// Bundle of requester, response and Booth-core signals shared by booth_mul_arbiter.
// slave = arbiter side, master = client/core side.
interface booth_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int BW   = 4,
  parameter int PW   = AW + BW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [PW-1:0]      rsp_product;
  logic               rsp_err;
  logic               core_start;
  logic [AW-1:0]      core_a;
  logic [BW-1:0]      core_b;
  logic               core_done;
  logic [PW-1:0]      core_product;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, core_done, core_product,
    output req_ready, rsp_valid, rsp_product, rsp_err, core_start, core_a, core_b
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, core_done, core_product,
    input  req_ready, rsp_valid, rsp_product, rsp_err, core_start, core_a, core_b
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier core among NREQ clients.
// Optional WAIT timeout abort enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int BW      = 4,
  parameter int PW      = AW + BW,
  parameter int TIMEOUT = 16,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_mul_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("booth_mul_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [AW-1:0]  a_q, a_d;
  logic [BW-1:0]  b_q, b_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [IDW-1:0] win;
  logic           win_vld;
  int             idx;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Scan from farthest to nearest so the requester closest after ptr wins last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        win     = IDW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (win_vld) begin
        gnt_d   = win;
        a_d     = bus.req_a[int'(win)*AW +: AW];
        b_d     = bus.req_b[int'(win)*BW +: BW];
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.core_done) begin
          prod_d  = bus.core_product;
          state_d = RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      RESP: if (bus.rsp_ready[gnt_q]) begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Accept strobe is combinational; gated by reset so every output reads 0 while held.
  assign bus.req_ready   = (state_q == IDLE && win_vld && rst) ? (NREQ'(1) << win) : '0;
  assign bus.rsp_valid   = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign bus.rsp_product = prod_q;
  assign bus.core_start  = (state_q == ISSUE);
  assign bus.core_a      = a_q;
  assign bus.core_b      = b_q;
  assign busy            = (state_q != IDLE);
  assign grant_id        = gnt_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign bus.rsp_err     = err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif
endmodule
